// File: rtl/mod_counter_decoder.sv
// Modulo-N counter with hold, up/down, parallel load, one-shot mode and
// several programmable decode channels. Decode strobes are registered and
// computed from the next count, so each one is high in the same cycles as the
// matching count value.
module mod_counter_decoder #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8,
    parameter int CH      = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  stop,
    input  logic                  up,
    input  logic                  one_shot,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [CH*WIDTH-1:0]   dec_val,
    input  logic [CH-1:0]         dec_en,
    output logic [WIDTH-1:0]      count,
    output logic [CH-1:0]         dec_out,
    output logic                  tc,
    output logic                  done
);

    // Largest legal count value, and the modulus widened by one bit so that
    // MODULUS == 2**WIDTH can still be compared against a WIDTH-bit value.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    // Reject a modulus that cannot be represented or that has no wrap.
    if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
        $error("mod_counter_decoder: MODULUS must lie in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic [CH-1:0]    dec_out_q, dec_out_d;

    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] step_up;
    logic [WIDTH-1:0] step_dn;
    logic [WIDTH-1:0] load_clamped;

    // Terminal value for the present direction and the wrapped neighbours.
    always_comb begin
        term_val     = up ? MAX_VAL : '0;
        step_up      = (count_q == MAX_VAL) ? '0 : count_q + 1'b1;
        step_dn      = (count_q == '0) ? MAX_VAL : count_q - 1'b1;
        load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
    end

    // Next count and done: load > done-freeze > stop > one-shot end > advance.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would infer a latch.
        count_d = count_q;
        done_d  = done_q;
        if (load) begin
            count_d = load_clamped;
            done_d  = 1'b0;
        end else if (done_q || stop) begin
            count_d = count_q;
        end else if (one_shot && (count_q == term_val)) begin
            done_d = 1'b1;
        end else begin
            count_d = up ? step_up : step_dn;
        end
    end

    // Decode against the next count so the registered strobe lines up with it.
    always_comb begin
        dec_out_d = '0;
        for (int i = 0; i < CH; i++) begin
            dec_out_d[i] = dec_en[i] && (count_d == dec_val[i*WIDTH +: WIDTH]);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            done_q    <= 1'b0;
            dec_out_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the
            // values present before the edge, independent of statement order.
            count_q   <= count_d;
            done_q    <= done_d;
            dec_out_q <= dec_out_d;
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign dec_out = dec_out_q;
    assign tc      = (count_q == term_val);

endmodule

// File: tb/tb_mod_counter_decoder.sv
// Bench for mod_counter_decoder: two instances (MODULUS 8 and 6) share one
// stimulus stream and are compared every cycle against an arithmetic model.
module tb_mod_counter_decoder;

    localparam int W   = 3;
    localparam int CHN = 2;

    logic             clock    = 1'b0;
    logic             reset_n  = 1'b0;
    logic             stop     = 1'b0;
    logic             up       = 1'b1;
    logic             one_shot = 1'b0;
    logic             load     = 1'b0;
    logic [W-1:0]     load_val = '0;
    logic [CHN*W-1:0] dec_val  = '0;
    logic [CHN-1:0]   dec_en   = '0;

    logic [W-1:0]   count8, count6;
    logic [CHN-1:0] dec8, dec6;
    logic           tc8, tc6, done8, done6;

    int total = 0;
    int bad   = 0;

    // Reference state: index 0 models MODULUS=8, index 1 models MODULUS=6.
    int m_cnt  [2];
    bit m_done [2];
    bit m_dec  [2][CHN];

    mod_counter_decoder #(.WIDTH(W), .MODULUS(8), .CH(CHN)) dut8 (
        .clock(clock), .reset_n(reset_n), .stop(stop), .up(up),
        .one_shot(one_shot), .load(load), .load_val(load_val),
        .dec_val(dec_val), .dec_en(dec_en),
        .count(count8), .dec_out(dec8), .tc(tc8), .done(done8)
    );

    mod_counter_decoder #(.WIDTH(W), .MODULUS(6), .CH(CHN)) dut6 (
        .clock(clock), .reset_n(reset_n), .stop(stop), .up(up),
        .one_shot(one_shot), .load(load), .load_val(load_val),
        .dec_val(dec_val), .dec_en(dec_en),
        .count(count6), .dec_out(dec6), .tc(tc6), .done(done6)
    );

    always #5 clock = ~clock;

    function automatic int mod_of(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_done[k] = 1'b0;
            for (int i = 0; i < CHN; i++) m_dec[k][i] = 1'b0;
        end
    endtask

    // One rising edge of the reference, from the present inputs.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int m;
            int term;
            m    = mod_of(k);
            term = up ? m - 1 : 0;
            if (load) begin
                m_cnt[k]  = (int'(load_val) >= m) ? m - 1 : int'(load_val);
                m_done[k] = 1'b0;
            end else if (m_done[k] || stop) begin
                m_cnt[k] = m_cnt[k];
            end else if (one_shot && m_cnt[k] == term) begin
                m_done[k] = 1'b1;
            end else begin
                m_cnt[k] = up ? (m_cnt[k] + 1) % m : (m_cnt[k] + m - 1) % m;
            end
            for (int i = 0; i < CHN; i++)
                m_dec[k][i] = dec_en[i] && (m_cnt[k] == int'(dec_val[i*W +: W]));
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            logic [W-1:0]   c;
            logic [CHN-1:0] d;
            logic [CHN-1:0] d_exp;
            logic           t, dn;
            int             m;
            m  = mod_of(k);
            c  = (k == 0) ? count8 : count6;
            d  = (k == 0) ? dec8   : dec6;
            t  = (k == 0) ? tc8    : tc6;
            dn = (k == 0) ? done8  : done6;
            for (int i = 0; i < CHN; i++) d_exp[i] = m_dec[k][i];
            check($sformatf("%s/m%0d/count", tag, m), 32'(c), 32'(m_cnt[k]));
            check($sformatf("%s/m%0d/dec_out", tag, m), 32'(d), 32'(d_exp));
            check($sformatf("%s/m%0d/tc", tag, m), 32'(t),
                  32'(m_cnt[k] == (up ? m - 1 : 0)));
            check($sformatf("%s/m%0d/done", tag, m), 32'(dn), 32'(m_done[k]));
        end
    endtask

    // Advance one clock, update the model, then compare 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        dec_val = {3'd7, 3'd2};
        dec_en  = 2'b11;
        #12;
        check_all("reset");
        reset_n = 1'b1;

        // Defaults: free-running up count, ch0=2, ch1=7.
        for (int n = 0; n < 20; n++) tick("defaults");

        // Hold at count 2 for three cycles.
        for (int n = 0; n < 10 && m_cnt[0] != 2; n++) tick("to_two");
        check("hold_reached", 32'(count8), 32'd2);
        stop = 1'b1;
        for (int n = 0; n < 3; n++) tick("hold");
        stop = 1'b0;
        for (int n = 0; n < 2; n++) tick("hold_release");

        // Down wrap after loading 1.
        up       = 1'b0;
        load     = 1'b1;
        load_val = 3'd1;
        tick("down_load");
        load = 1'b0;
        for (int n = 0; n < 8; n++) tick("down");

        // One-shot from 0 counting up.
        up       = 1'b1;
        load     = 1'b1;
        load_val = 3'd0;
        tick("os_load");
        load     = 1'b0;
        one_shot = 1'b1;
        for (int n = 0; n < 10; n++) tick("one_shot");
        check("os_done_set", 32'(done6), 32'd1);
        stop = 1'b1;
        up   = 1'b0;
        tick("os_frozen");
        stop     = 1'b0;
        up       = 1'b1;
        load     = 1'b1;
        load_val = 3'd2;
        tick("os_reload");
        load = 1'b0;
        for (int n = 0; n < 5; n++) tick("os_resume");
        one_shot = 1'b0;

        // Load clamp together with stop.
        stop     = 1'b1;
        load     = 1'b1;
        load_val = 3'd7;
        tick("clamp");
        check("clamp_m6", 32'(count6), 32'd5);
        load = 1'b0;
        stop = 1'b0;
        tick("clamp_after");

        // Asynchronous reset between edges at count 4.
        dec_val = {3'd4, 3'd1};
        for (int n = 0; n < 10 && m_cnt[0] != 4; n++) tick("to_four");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        reset_n = 1'b1;
        tick("post_rst");
        check("post_rst_one", 32'(count8), 32'd1);

        // Randomised phase.
        for (int n = 0; n < 600; n++) begin
            stop     = ($urandom_range(0, 3) == 0);
            up       = ($urandom_range(0, 3) != 0);
            one_shot = ($urandom_range(0, 4) == 0);
            load     = ($urandom_range(0, 9) == 0);
            load_val = W'($urandom);
            dec_en   = CHN'($urandom);
            if ($urandom_range(0, 7) == 0) dec_val = (CHN*W)'($urandom);
            if ($urandom_range(0, 79) == 0) begin
                #2;
                reset_n = 1'b0;
                #1;
                model_reset();
                check_all("rand_rst");
                #1;
                reset_n = 1'b1;
            end
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
